fifo_read_ctrl: RTL

Read-domain pointer and flag logic for the dual-clock FIFO, the counterpart to the write-side control. It brings the write pointer into the read domain through a synchronizer and maintains the binary and Gray read pointers. It generates the registered empty flag, the RAM read address and a fill-level estimate. Its Gray read pointer is exported for synchronization into the write domain, where it drives the full flag.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_read_ctrl_sync_ff_chain.sv | 31 +++
 rtl/fifo_read_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default sizing and the
// binary/Gray pointer conversions used by both the read and write sides.
package fifo_pkg;

    localparam int PTR_SZ_DEFAULT = 2;

    // Conversions work on a wide carrier vector.
    // Callers zero-extend their pointer into it and cast the result back.
    // Leading zeros are invariant under both transforms, so any pointer
    // width up to CODE_W is handled.
    localparam int CODE_W = 32;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_sync_ff_chain.sv
// Multi-stage flip-flop synchronizer for Gray-coded pointers crossing
// between the FIFO clock domains. No logic is placed between stages.
module sync_ff_chain #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_stages [STAGES];

    // Shift the incoming pointer through the chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stages[i] <= '0;
            end
        end else begin
            r_stages[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign q = r_stages[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side pointer and flag control for the dual-clock FIFO.
// The block keeps the binary and Gray read pointers and brings the write
// pointer into the read domain. From these it derives the registered empty
// flag and a registered fill-level estimate. raddr and read_en are the only
// combinational outputs, and they never depend on wptr_gray.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_SZ      = PTR_SZ_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rinc,
    input  logic [PTR_SZ:0]   wptr_gray,
    output logic              rempty,
    output logic              read_en,
    output logic [PTR_SZ-1:0] raddr,
    output logic [PTR_SZ:0]   raddr_gray,
    output logic [PTR_SZ:0]   rlevel
);

    localparam int PTR_W = PTR_SZ + 1;

    logic [PTR_W-1:0] r_rbin;
    logic [PTR_W-1:0] r_rgray;
    logic             r_rempty;
    logic [PTR_W-1:0] r_rlevel;

    logic [PTR_W-1:0] w_rq_wptr;
    logic             w_rd;
    logic [PTR_W-1:0] w_rbin_next;
    logic [PTR_W-1:0] w_rgray_next;
    logic [PTR_W-1:0] w_wbin;
    logic [PTR_W-1:0] w_level_next;

    // The write pointer is Gray coded, so at most one bit is in flight per
    // write. This keeps the synchronized value either the old or the new
    // pointer.
    sync_ff_chain #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (clk),
        .rst (rst),
        .d   (wptr_gray),
        .q   (w_rq_wptr)
    );

    // A read only takes effect while the FIFO holds data.
    assign w_rd        = rinc & ~r_rempty;
    assign w_rbin_next = r_rbin + PTR_W'(w_rd);

    assign w_rgray_next = PTR_W'(bin2gray(CODE_W'(w_rbin_next)));
    assign w_wbin       = PTR_W'(gray2bin(CODE_W'(w_rq_wptr)));

    // The subtraction wraps modulo 2**PTR_W.
    // Depth itself shows up as MSBs differing with the low bits equal.
    assign w_level_next = w_wbin - w_rbin_next;

    // Advance the read pointers.
    // Empty is evaluated against the post-read pointer, so the edge that
    // consumes the last entry already raises rempty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rbin   <= '0;
            r_rgray  <= '0;
            r_rempty <= 1'b1;
            r_rlevel <= '0;
        end else begin
            r_rbin   <= w_rbin_next;
            r_rgray  <= w_rgray_next;
            r_rempty <= (w_rgray_next == w_rq_wptr);
            r_rlevel <= w_level_next;
        end
    end

    assign rempty     = r_rempty;
    assign read_en    = w_rd;
    assign raddr      = r_rbin[PTR_SZ-1:0];
    assign raddr_gray = r_rgray;
    assign rlevel     = r_rlevel;

endmodule
